// File: rtl/axi_ram_burst.sv
// axi_ram_burst: AXI4 slave RAM for scratch/test memory behind an interconnect.
// Supports FIXED/INCR/WRAP bursts, narrow transfers through wstrb, a memory
// smaller than the address window (beats at or above MEM_BYTES give SLVERR),
// and PORT_MODE 0 (independent read/write) or 1 (one burst at a time).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   s_axi_aw*                write address channel (lock/cache/prot ignored)
//   s_axi_w*                 write data channel (wlast ignored, awlen counts beats)
//   s_axi_b*                 write response channel
//   s_axi_ar*                read address channel (lock/cache/prot ignored)
//   s_axi_r*                 read data channel
//
// State table
//   W_IDLE  | waiting for AW, awready raised when allowed
//   W_BURST | accepting awlen+1 data beats
//   W_RESP  | burst done, waiting for the B register to free up
//   R_IDLE  | waiting for AR, arready raised when allowed
//   R_BURST | issuing arlen+1 read beats
//   arbiter (PORT_MODE 1): OWN_NONE | OWN_WR | OWN_RD owns the memory

module axi_ram_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_BYTES  = 2 ** ADDR_WIDTH,
  parameter int PORT_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int ADDR_LSB  = $clog2(STRB_WIDTH);
  localparam int MEM_WORDS = MEM_BYTES / STRB_WIDTH;
  localparam int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot};

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < MEM_LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_LSB +: IDX_W];
  endfunction

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > 3'(ADDR_LSB)) ? 3'(ADDR_LSB) : s;
  endfunction

  // Address of the following beat; size is already clamped to the bus width.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10: begin
        // Only legal wrap lengths wrap; anything else behaves as INCR.
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
          next_addr = (a & ~mask) | ((a + step) & mask);
        else
          next_addr = (a & ~(step - ADDR_WIDTH'(1))) + step;
      end
      default: next_addr = (a & ~(step - ADDR_WIDTH'(1))) + step;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_BURST}         r_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_WR, OWN_RD} owner_t;

  w_state_t              w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;

  r_state_t              r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;

  owner_t arb_owner;
  logic   prio_rd;

  logic w_fire, b_free, w_beat_err, mem_we, aw_allow, ar_allow;
  logic r_issue, r_last_issue;

  assign w_fire       = s_axi_wvalid && s_axi_wready;
  assign b_free       = !s_axi_bvalid || s_axi_bready;
  assign w_beat_err   = !in_range(w_addr);
  assign mem_we       = (w_state == W_BURST) && w_fire && !w_beat_err;
  assign r_issue      = (r_state == R_BURST) && (!s_axi_rvalid || s_axi_rready);
  assign r_last_issue = r_issue && (r_cnt == r_len);

  // In single-port mode a write may not start while its previous B is still
  // pending, since the arbiter only releases on B acceptance.
  assign aw_allow = (PORT_MODE == 0) || ((arb_owner == OWN_WR) && !s_axi_bvalid);
  assign ar_allow = (PORT_MODE == 0) || (arb_owner == OWN_RD);

  // Memory has no reset so contents survive an aborted burst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[word_idx(w_addr)][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
    end else begin
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= clamp_size(s_axi_awsize);
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_BURST;
          end else begin
            s_axi_awready <= aw_allow;
          end
        end
        W_BURST: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            if (w_beat_err) w_err <= 1'b1;
            if (w_cnt == w_len) begin
              s_axi_wready <= 1'b0;
              if (b_free) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bid    <= w_id;
                s_axi_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                w_state      <= W_IDLE;
              end else begin
                w_state <= W_RESP;
              end
            end
          end
        end
        W_RESP: begin
          if (b_free) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bid    <= w_id;
            s_axi_bresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      r_id          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      s_axi_rlast   <= 1'b0;
    end else begin
      if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            r_id          <= s_axi_arid;
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= clamp_size(s_axi_arsize);
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            r_state       <= R_BURST;
          end else begin
            s_axi_arready <= ar_allow;
          end
        end
        R_BURST: begin
          if (r_issue) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rid    <= r_id;
            s_axi_rdata  <= in_range(r_addr) ? mem[word_idx(r_addr)] : '0;
            s_axi_rresp  <= in_range(r_addr) ? RESP_OKAY : RESP_SLVERR;
            s_axi_rlast  <= (r_cnt == r_len);
            r_addr       <= next_addr(r_addr, r_len, r_size, r_burst);
            r_cnt        <= r_cnt + 8'd1;
            if (r_cnt == r_len) r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Priority flips only when both requests collide, so contended grants
  // alternate starting with the write side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_owner <= OWN_NONE;
      prio_rd   <= 1'b0;
    end else begin
      case (arb_owner)
        OWN_NONE: begin
          if (s_axi_awvalid && (!s_axi_arvalid || !prio_rd)) begin
            arb_owner <= OWN_WR;
            if (s_axi_arvalid) prio_rd <= 1'b1;
          end else if (s_axi_arvalid) begin
            arb_owner <= OWN_RD;
            if (s_axi_awvalid) prio_rd <= 1'b0;
          end
        end
        OWN_WR:  if (s_axi_bvalid && s_axi_bready) arb_owner <= OWN_NONE;
        OWN_RD:  if (r_last_issue) arb_owner <= OWN_NONE;
        default: arb_owner <= OWN_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_burst.sv
module tb_axi_ram_burst;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int IW = 8;

  typedef logic [DW-1:0] beat4_t [4];
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, arvalid, wvalid, wlast, bready, rready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;

  logic          awready0, wready0, bvalid0, arready0, rvalid0, rlast0;
  logic          awready1, wready1, bvalid1, arready1, rvalid1, rlast1;
  logic [IW-1:0] bid0, rid0, bid1, rid1;
  logic [1:0]    bresp0, rresp0, bresp1, rresp1;
  logic [DW-1:0] rdata0, rdata1;

  // sel picks which instance the bench is talking to: 0 = dual port, 1 = arbitrated
  logic          sel;
  logic          awready, wready, bvalid, arready, rvalid, rlast;
  logic [IW-1:0] bid, rid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;
  assign awready = sel ? awready1 : awready0;
  assign wready  = sel ? wready1  : wready0;
  assign bvalid  = sel ? bvalid1  : bvalid0;
  assign bid     = sel ? bid1     : bid0;
  assign bresp   = sel ? bresp1   : bresp0;
  assign arready = sel ? arready1 : arready0;
  assign rvalid  = sel ? rvalid1  : rvalid0;
  assign rid     = sel ? rid1     : rid0;
  assign rdata   = sel ? rdata1   : rdata0;
  assign rresp   = sel ? rresp1   : rresp0;
  assign rlast   = sel ? rlast1   : rlast0;

  axi_ram_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_BYTES(256), .PORT_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready0),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready0),
    .s_axi_bid(bid0), .s_axi_bresp(bresp0), .s_axi_bvalid(bvalid0), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready0),
    .s_axi_rid(rid0), .s_axi_rdata(rdata0), .s_axi_rresp(rresp0), .s_axi_rlast(rlast0),
    .s_axi_rvalid(rvalid0), .s_axi_rready(rready)
  );

  axi_ram_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_BYTES(256), .PORT_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready1),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready1),
    .s_axi_bid(bid1), .s_axi_bresp(bresp1), .s_axi_bvalid(bvalid1), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready1),
    .s_axi_rid(rid1), .s_axi_rdata(rdata1), .s_axi_rresp(rresp1), .s_axi_rlast(rlast1),
    .s_axi_rvalid(rvalid1), .s_axi_rready(rready)
  );

  b_exp_t bq[$];
  r_exp_t rq[$];
  int n_chk = 0;
  int n_fail = 0;
  int both_rdy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: handshake not seen within 200 cycles, required within 200", name);
  endtask

  // Monitor: pops the scoreboard whenever the selected DUT completes a B or R beat.
  initial begin
    b_exp_t be;
    r_exp_t re;
    logic stall_prev;
    logic [DW-1:0] data_prev;
    logic last_prev;
    stall_prev = 1'b0;
    data_prev = '0;
    last_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        continue;
      end
      if (awready1 && arready1) both_rdy++;
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_b: got bid 0x%0h bresp %0d, required no response", bid, bresp);
        end else begin
          be = bq.pop_front();
          check("bid", 64'(bid), 64'(be.id));
          check("bresp", 64'(bresp), 64'(be.resp));
        end
      end
      if (rvalid) begin
        if (stall_prev) begin
          check("rdata_stall", 64'(rdata), 64'(data_prev));
          check("rlast_stall", 64'(rlast), 64'(last_prev));
        end
        if (rready) begin
          if (rq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_r: got rid 0x%0h rdata 0x%0h, required no beat", rid, rdata);
          end else begin
            re = rq.pop_front();
            check("rid", 64'(rid), 64'(re.id));
            check("rdata", 64'(rdata), 64'(re.data));
            check("rresp", 64'(rresp), 64'(re.resp));
            check("rlast", 64'(rlast), 64'(re.last));
          end
        end
      end
      stall_prev = rvalid && !rready;
      data_prev = rdata;
      last_prev = rlast;
    end
  end

  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    logic hs;
    n = 0;
    hs = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1; n++;
    end
    awvalid = 1'b0;
    if (!hs) timeout("aw_handshake");
  endtask

  task automatic do_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
    int n;
    logic hs;
    n = 0;
    hs = 1'b0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk); hs = wready;
      @(posedge clk); #1; n++;
    end
    wvalid = 1'b0;
    if (!hs) timeout("w_handshake");
  endtask

  task automatic do_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    logic hs;
    n = 0;
    hs = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1; n++;
    end
    arvalid = 1'b0;
    if (!hs) timeout("ar_handshake");
  endtask

  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input beat4_t d,
                             input logic [SW-1:0] s, input logic [1:0] resp);
    bq.push_back('{id: id, resp: resp});
    do_aw(id, addr, 8'(len), size, burst);
    for (int i = 0; i <= len; i++) do_w(d[i], s, i == len);
  endtask

  // Beats with index >= n_ok are expected as SLVERR with zero data.
  task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input beat4_t d,
                            input int n_ok);
    for (int i = 0; i <= len; i++)
      rq.push_back('{id: id, data: (i < n_ok) ? d[i] : '0,
                     resp: (i < n_ok) ? 2'b00 : 2'b10, last: (i == len)});
    do_ar(id, addr, 8'(len), size, burst);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: %0d B and %0d R responses outstanding, required 0", name, bq.size(), rq.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2000000, required to finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    beat4_t d, e;
    rst = 1'b1; sel = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1; rready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready0", 64'(awready0), 64'd0);
    check("rst_arready0", 64'(arready0), 64'd0);
    check("rst_bvalid0", 64'(bvalid0), 64'd0);
    check("rst_rvalid0", 64'(rvalid0), 64'd0);
    check("rst_rdata0", 64'(rdata0), 64'd0);
    check("rst_awready1", 64'(awready1), 64'd0);
    check("rst_arready1", 64'(arready1), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel_awready0_before_edge", 64'(awready0), 64'd0);
    @(negedge clk);
    check("rel_awready0", 64'(awready0), 64'd1);
    check("rel_arready0", 64'(arready0), 64'd1);
    check("rel_awready1_idle", 64'(awready1), 64'd0);
    @(posedge clk); #1;

    // Arbitrated instance: first collision goes to the write, so the read sees new data.
    d = '{32'hC0, 32'hC1, 32'h0, 32'h0};
    fork
      write_burst(8'h01, 16'h0040, 1, 3'd2, 2'b01, d, 4'hF, 2'b00);
      read_burst(8'h02, 16'h0040, 1, 3'd2, 2'b01, d, 2);
    join
    drain("contention1");
    // Second collision goes to the read, which still sees the first write's data.
    e = '{32'hD0, 32'hD1, 32'h0, 32'h0};
    fork
      write_burst(8'h03, 16'h0040, 1, 3'd2, 2'b01, e, 4'hF, 2'b00);
      read_burst(8'h04, 16'h0040, 1, 3'd2, 2'b01, d, 2);
    join
    drain("contention2");
    read_burst(8'h05, 16'h0040, 1, 3'd2, 2'b01, e, 2);
    drain("contention_after");

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 sel = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    d = '{32'd1, 32'd2, 32'd3, 32'd4};
    write_burst(8'h11, 16'h0010, 3, 3'd2, 2'b01, d, 4'hF, 2'b00);
    read_burst(8'h12, 16'h0010, 3, 3'd2, 2'b01, d, 4);
    drain("incr");

    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    write_burst(8'h21, 16'h0030, 3, 3'd2, 2'b01, d, 4'hF, 2'b00);
    e = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
    read_burst(8'h22, 16'h0038, 3, 3'd2, 2'b10, e, 4);
    e = '{32'hA2, 32'hA2, 32'hA2, 32'hA2};
    read_burst(8'h23, 16'h0038, 3, 3'd2, 2'b00, e, 4);
    drain("wrap_fixed");

    d = '{32'h11223344, 32'h0, 32'h0, 32'h0};
    write_burst(8'h31, 16'h0020, 0, 3'd2, 2'b01, d, 4'hF, 2'b00);
    d = '{32'h0000AB00, 32'h0, 32'h0, 32'h0};
    write_burst(8'h32, 16'h0021, 0, 3'd0, 2'b01, d, 4'b0010, 2'b00);
    e = '{32'h1122AB44, 32'h0, 32'h0, 32'h0};
    read_burst(8'h33, 16'h0020, 0, 3'd2, 2'b01, e, 1);
    drain("narrow");

    d = '{32'd5, 32'd6, 32'd7, 32'd8};
    write_burst(8'h41, 16'h00F8, 3, 3'd2, 2'b01, d, 4'hF, 2'b10);
    read_burst(8'h42, 16'h00F8, 3, 3'd2, 2'b01, d, 2);
    drain("out_of_range");

    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    fork
      read_burst(8'h51, 16'h0030, 3, 3'd2, 2'b01, d, 4);
      begin
        repeat (3) @(posedge clk);
        #1 rready = 1'b0;
        repeat (5) @(posedge clk);
        #1 rready = 1'b1;
      end
    join
    drain("stall");

    // Abort a write after two beats; no B may follow and the beats already stored stay.
    do_aw(8'h61, 16'h0050, 8'd3, 3'd2, 2'b01);
    do_w(32'hE0, 4'hF, 1'b0);
    do_w(32'hE1, 4'hF, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_awready_at_release", 64'(awready0), 64'd0);
    check("abort_bvalid", 64'(bvalid0), 64'd0);
    check("abort_wready", 64'(wready0), 64'd0);
    @(negedge clk);
    check("abort_awready_next", 64'(awready0), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    d = '{32'd1, 32'd2, 32'd3, 32'd4};
    read_burst(8'h62, 16'h0010, 3, 3'd2, 2'b01, d, 4);
    e = '{32'hE0, 32'hE1, 32'h0, 32'h0};
    read_burst(8'h63, 16'h0050, 1, 3'd2, 2'b01, e, 2);
    drain("after_abort");

    check("ready_exclusive_cycles", 64'(both_rdy), 64'd0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
